// File: rtl/flipflop_state_bank.sv
// Registered state bank for hand-derived FSMs: D/SR/T/JK state update selected by mode_i,
// plus a cross-check of the D, SR and T excitations with a saturating disagreement counter.
module flipflop_state_bank #(
   parameter int unsigned         WIDTH       = 4,
   parameter logic [WIDTH-1:0]    RESET_STATE = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [1:0]       mode_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic [WIDTH-1:0] s_i,
   input  logic [WIDTH-1:0] r_i,
   input  logic [WIDTH-1:0] t_i,
   input  logic             clr_err_i,
   output logic [WIDTH-1:0] q_o,
   output logic             changed_o,
   output logic             sr_conflict_o,
   output logic [WIDTH-1:0] mismatch_o,
   output logic [7:0]       err_count_o
);

   typedef enum logic [1:0] {
      ModeD  = 2'b00,
      ModeSr = 2'b01,
      ModeT  = 2'b10,
      ModeJk = 2'b11
   } mode_e;

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] mismatch_q, mismatch_d;
   logic             changed_q, changed_d;
   logic             sr_conflict_q, sr_conflict_d;
   logic [7:0]       err_count_q, err_count_d;

   logic [WIDTH-1:0] sr_next, jk_next, t_next, q_next, mm_calc;

   // SR: set on 10, reset on 01, hold on 00 and on the illegal 11.
   assign sr_next = (s_i & ~r_i) | (q_q & (s_i | ~r_i));
   assign jk_next = (s_i & ~q_q) | (~r_i & q_q);
   assign t_next  = q_q ^ t_i;
   assign mm_calc = (sr_next ^ d_i) | (s_i & r_i) | (t_next ^ d_i);

   // The mux keeps unused excitations (possibly X) out of q.
   always_comb begin
      q_next = q_q;
      unique case (mode_e'(mode_i))
         ModeD:   q_next = d_i;
         ModeSr:  q_next = sr_next;
         ModeT:   q_next = t_next;
         ModeJk:  q_next = jk_next;
         default: q_next = q_q;
      endcase
   end

   always_comb begin
      q_d           = q_q;
      changed_d     = 1'b0;
      sr_conflict_d = 1'b0;
      mismatch_d    = '0;
      err_count_d   = err_count_q;
      if (en_i) begin
         q_d           = q_next;
         changed_d     = (q_next != q_q);
         sr_conflict_d = (mode_i == ModeSr) && (|(s_i & r_i));
         mismatch_d    = mm_calc;
         if ((|mm_calc) && (err_count_q != 8'hff)) begin
            err_count_d = err_count_q + 8'd1;
         end
      end
      if (clr_err_i) begin
         err_count_d = 8'd0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q           <= RESET_STATE;
         changed_q     <= 1'b0;
         sr_conflict_q <= 1'b0;
         mismatch_q    <= '0;
         err_count_q   <= 8'd0;
      end else begin
         q_q           <= q_d;
         changed_q     <= changed_d;
         sr_conflict_q <= sr_conflict_d;
         mismatch_q    <= mismatch_d;
         err_count_q   <= err_count_d;
      end
   end

   assign q_o           = q_q;
   assign changed_o     = changed_q;
   assign sr_conflict_o = sr_conflict_q;
   assign mismatch_o    = mismatch_q;
   assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_flipflop_state_bank.sv
// Directed table-driven bench for flipflop_state_bank plus hand sequences for reset,
// X isolation and counter saturation/clear.
module tb_flipflop_state_bank;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic [1:0]   mode;
   logic [W-1:0] d, s, r, t;
   logic         clr_err;
   logic [W-1:0] q;
   logic         changed;
   logic         sr_conflict;
   logic [W-1:0] mismatch;
   logic [7:0]   err_count;

   int n_pass  = 0;
   int n_total = 0;

   flipflop_state_bank #(
      .WIDTH       (W),
      .RESET_STATE (4'b0000)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .en_i          (en),
      .mode_i        (mode),
      .d_i           (d),
      .s_i           (s),
      .r_i           (r),
      .t_i           (t),
      .clr_err_i     (clr_err),
      .q_o           (q),
      .changed_o     (changed),
      .sr_conflict_o (sr_conflict),
      .mismatch_o    (mismatch),
      .err_count_o   (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         en;
      logic [1:0]   mode;
      logic [W-1:0] d, s, r, t;
      logic         clr;
      logic [W-1:0] q;
      logic         chg;
      logic         conf;
      logic [W-1:0] mm;
      logic [7:0]   err;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drive(input logic e, input logic [1:0] m, input logic [W-1:0] dd,
                        input logic [W-1:0] ss, input logic [W-1:0] rr,
                        input logic [W-1:0] tt, input logic c);
      @(negedge clk);
      en = e; mode = m; d = dd; s = ss; r = rr; t = tt; clr_err = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            en mode   d        s        r        t        clr  q        chg  conf mm       err
      vecs[0]  = '{1'b1, 2'b00, 4'b0101, 4'b0101, 4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000, 8'd0};
      vecs[1]  = '{1'b0, 2'b00, 4'b0101, 4'b0101, 4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000, 8'd0};
      vecs[2]  = '{1'b1, 2'b00, 4'b0001, 4'b0001, 4'b1110, 4'b0100, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 8'd0};
      vecs[3]  = '{1'b1, 2'b01, 4'b0001, 4'b0011, 4'b0010, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 4'b0010, 8'd1};
      vecs[4]  = '{1'b1, 2'b01, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 8'd1};
      vecs[5]  = '{1'b1, 2'b00, 4'b0110, 4'b0110, 4'b1001, 4'b0111, 1'b0, 4'b0110, 1'b1, 1'b0, 4'b0000, 8'd1};
      vecs[6]  = '{1'b1, 2'b11, 4'b1001, 4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b1001, 1'b1, 1'b0, 4'b1111, 8'd2};
      vecs[7]  = '{1'b1, 2'b11, 4'b1001, 4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0110, 1'b1, 1'b0, 4'b1111, 8'd3};
      vecs[8]  = '{1'b1, 2'b00, 4'b0000, 4'b0000, 4'b1111, 4'b0110, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'd3};
      vecs[9]  = '{1'b1, 2'b10, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0001, 8'd4};
      vecs[10] = '{1'b0, 2'b10, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 8'd0};
      vecs[11] = '{1'b1, 2'b11, 4'b1000, 4'b1000, 4'b0001, 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000, 8'd0};
      vecs[12] = '{1'b1, 2'b01, 4'b0001, 4'b0001, 4'b1000, 4'b1001, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 8'd0};
      vecs[13] = '{1'b1, 2'b10, 4'b1110, 4'b1110, 4'b0001, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 4'b0000, 8'd0};
      vecs[14] = '{1'b1, 2'b10, 4'b1110, 4'b1110, 4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b1111, 8'd1};

      rst_n = 1'b0; en = 1'b0; mode = 2'b00; d = '0; s = '0; r = '0; t = '0; clr_err = 1'b0;
      #12;
      check("reset_q", {4'b0, q}, 8'h00);
      check("reset_changed", {7'b0, changed}, 8'h00);
      check("reset_conflict", {7'b0, sr_conflict}, 8'h00);
      check("reset_mismatch", {4'b0, mismatch}, 8'h00);
      check("reset_err", err_count, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].s, vecs[i].r, vecs[i].t,
               vecs[i].clr);
         check($sformatf("v%0d_q", i), {4'b0, q}, {4'b0, vecs[i].q});
         check($sformatf("v%0d_changed", i), {7'b0, changed}, {7'b0, vecs[i].chg});
         check($sformatf("v%0d_conflict", i), {7'b0, sr_conflict}, {7'b0, vecs[i].conf});
         check($sformatf("v%0d_mismatch", i), {4'b0, mismatch}, {4'b0, vecs[i].mm});
         check($sformatf("v%0d_err", i), err_count, vecs[i].err);
      end

      // X on unused excitations must not reach q (q=0001, err=1 here)
      drive(1'b1, 2'b00, 4'b0101, 4'bxxxx, 4'bxxxx, 4'bxxxx, 1'b0);
      check("xd_q", {4'b0, q}, 8'h05);
      drive(1'b1, 2'b10, 4'bxxxx, 4'bxxxx, 4'bxxxx, 4'b0011, 1'b0);
      check("xt_q", {4'b0, q}, 8'h06);
      drive(1'b1, 2'b11, 4'bxxxx, 4'b1000, 4'b0100, 4'bxxxx, 1'b1);
      check("xjk_q", {4'b0, q}, 8'h0a);
      check("xjk_err_clr", err_count, 8'h00);

      // Saturation: constant SR/D disagreement on bit 0
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 2'b00, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
         if (i == 9) check("sat_err_10", err_count, 8'd10);
      end
      check("sat_err_255", err_count, 8'd255);
      check("sat_mismatch", {4'b0, mismatch}, 8'h01);
      drive(1'b1, 2'b00, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      check("sat_hold", err_count, 8'd255);
      drive(1'b1, 2'b00, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      check("clr_priority", err_count, 8'd0);
      drive(1'b1, 2'b00, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      check("after_clr", err_count, 8'd1);
      drive(1'b0, 2'b00, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      check("en0_err_hold", err_count, 8'd1);
      check("en0_mm_zero", {4'b0, mismatch}, 8'h00);

      // Mid-run asynchronous reset from q=1011
      drive(1'b1, 2'b00, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      check("pre_rst_q", {4'b0, q}, 8'h0b);
      check("pre_rst_err", err_count, 8'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_q", {4'b0, q}, 8'h00);
      check("async_rst_err", err_count, 8'h00);
      check("async_rst_changed", {7'b0, changed}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b0;
      drive(1'b0, 2'b00, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      drive(1'b0, 2'b00, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      check("post_rst_hold_q", {4'b0, q}, 8'h00);
      drive(1'b1, 2'b00, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 1'b0);
      check("post_rst_first_q", {4'b0, q}, 8'h0f);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/flipflop_state_bank.md
Name: flipflop_state_bank

Overview:
Registered state bank for the hand-derived FSM designs. It consumes the D, SR, and T excitation signals produced by the per-bit excitation logic and updates the state vector each clock using a selectable flip-flop type: D, SR, T, or JK. The same state vector feeds back as the a/b/c/d state inputs of the excitation logic. It also cross-checks that the D, SR, and T excitations agree, and counts disagreements, so that bad hand-minimised SoP equations show up in simulation.

Parameters:
WIDTH, 4, number of state bits (flip-flops)
RESET_STATE, 0 (WIDTH bits), value loaded into q on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  update enable; when 0 the state holds
mode  in  2  flip-flop type: 00=D, 01=SR, 10=T, 11=JK
d  in  WIDTH  D excitation per bit
s  in  WIDTH  S excitation per bit; J in JK mode
r  in  WIDTH  R excitation per bit; K in JK mode
t  in  WIDTH  T excitation per bit
clr_err  in  1  synchronous clear of err_count
q  out  WIDTH  current state, registered
changed  out  1  one-cycle pulse: q differs from its previous value
sr_conflict  out  1  one-cycle pulse: s&r=1 on some bit in SR mode
mismatch  out  WIDTH  per-bit excitation disagreement, registered
err_count  out  8  saturating count of cycles with any mismatch

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-run):
  - q=RESET_STATE
  - changed=0, sr_conflict=0, mismatch=0, err_count=0
- Reset release: first update on the first rising edge with rst_n=1 and en=1.
- Rising edge with en=1, per bit i (all bits use the same mode):
  - D: q[i]<=d[i].
  - SR: s=1,r=0 -> 1; s=0,r=1 -> 0; s=0,r=0 -> hold; s=1,r=1 -> hold that bit, and sr_conflict<=1 for the next cycle.
  - T: q[i]<=q[i]^t[i].
  - JK: J=1,K=0 -> 1; J=0,K=1 -> 0; J=0,K=0 -> hold; J=1,K=1 -> toggle. No conflict is flagged in JK mode.
- Cross-check on every en=1 edge, independent of mode, using the q value before the edge:
  - mismatch[i]<=1 if any of the following holds:
    - the SR-predicted next value differs from d[i]
    - s[i]&r[i]=1
    - q[i]^t[i] differs from d[i]
  - The SR prediction follows the SR rules above.
  - mismatch is registered on the same edge as q, so its latency matches q.
- err_count:
  - On an en=1 edge where any computed mismatch bit is 1, err_count increments by 1.
  - Saturates at 255 and never wraps.
  - clr_err=1 at an edge forces err_count to 0. This has priority over an increment in the same cycle.
  - clr_err works regardless of en.
- changed<=1 when the new q differs from the old q, otherwise 0. It is a single-cycle pulse.
- Edge with en=0:
  - q holds; changed, sr_conflict, and mismatch go to 0.
  - err_count holds, unless clr_err=1.
- A mode change takes effect at the next enabled edge. No internal mode state exists.
- No combinational path from inputs to outputs; all outputs are registered.
- X/Z on unused excitation inputs must not corrupt q. In D mode q depends only on d, in SR/JK only on s/r, and in T only on t. The cross-check may flag mismatch from X inputs.

Test Plan:
- Reset mid-run: q=4'b1011, assert rst_n=0 between clock edges -> q=0000 immediately; err_count=0; after release with en=0, q stays 0000.
- D mode, agreeing excitations: q=0000, d=0101, s=0101, r=1010, t=0101, en=1 -> after 1 edge q=0101, changed=1, mismatch=0000, err_count=0.
- SR conflict: mode=01, q=0001, s=0011, r=0010 -> bit1 held at 0, bit0 stays 1, q=0001, sr_conflict=1 for exactly 1 cycle, mismatch[1]=1, err_count=1.
- JK toggle: mode=11, q=0110, s=1111, r=1111 -> q=1001, changed=1, sr_conflict=0; repeated edge -> q=0110.
- T mode with bad d: mode=10, q=0000, t=0001, d=0000, s=0001, r=0000 -> q=0001, mismatch=0001 (T and SR disagree with d), err_count increments by 1.
- Saturation and clear: force a mismatch for 300 enabled edges -> err_count=255 and holds; clr_err=1 while the mismatch continues -> err_count=0 next cycle, then 1 on the following edge.
